// File: rtl/systemverilog_bus_serializer_pkg.sv
// Shared types and helpers for the bus-to-stream serializer.
// No logic; beat count helper is evaluated at elaboration.
package package_str;

    function automatic int f_beats(input int pw, input int sw);
        return (pw + sw - 1) / sw;
    endfunction

    typedef enum logic {SER_LSB, SER_MSB} t_ser_order;
    typedef enum logic {SER_ADR_DAT, SER_DAT} t_ser_mode;

endpackage

package package_bus;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } t_bus;

endpackage

// File: rtl/systemverilog_bus_serializer_fifo.sv
// Packet FIFO, DEPTH entries of PW bits; head is registered storage (0 cycles read).
// Latency: a push is visible at head the next cycle; writes are dropped while full.
module systemverilog_bus_fifo #(
    parameter int DEPTH = 2,
    parameter int PW    = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [PW-1:0] push_dat,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] head
);
    localparam int IW = $clog2(DEPTH);

    logic [PW-1:0] mem [DEPTH];
    logic [IW:0]   wr_ptr;
    logic [IW:0]   rd_ptr;
    logic          wr_en;
    logic          rd_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign head  = mem[rd_ptr[IW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[IW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/systemverilog_bus_serializer.sv
// Serialises buffered bus writes into N beats of SW bits with a last-beat marker.
// Latency 1 cycle bus->stream; bus_rdy drops while the FIFO is full, beats hold until str_rdy.
module systemverilog_bus_serializer
    import package_str::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int SW    = 8,
    parameter int DEPTH = 2,
    parameter int ORDER = 0,
    parameter int MODE  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bus_vld,
    input  logic [AW-1:0] bus_adr,
    input  logic [DW-1:0] bus_dat,
    output logic          bus_rdy,
    output logic          str_vld,
    output logic [SW-1:0] str_bus,
    output logic          str_lst,
    input  logic          str_rdy
);
    localparam int PW = (MODE == int'(SER_DAT)) ? DW : AW + DW;
    localparam int N  = f_beats(PW, SW);
    localparam int XW = N * SW;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [PW-1:0] pkt;
    logic [PW-1:0] head;
    logic [XW-1:0] head_x;
    logic [SW-1:0] beat;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          str_trn;

    generate
        if (MODE == int'(SER_DAT)) begin : g_dat
            logic unused_adr;
            assign unused_adr = ^bus_adr;
            assign pkt        = bus_dat;
        end else begin : g_adr_dat
            assign pkt = {bus_adr, bus_dat};
        end
    endgenerate

    assign bus_rdy = ~full;
    assign push    = bus_vld & ~full;
    assign str_vld = ~empty;
    assign str_trn = str_vld & str_rdy;
    assign str_lst = str_vld & (cnt == LAST);
    assign pop     = str_trn & str_lst;

    systemverilog_bus_fifo #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (pkt),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    // Zero padding lands in the top beat, so MSB-first emits it first.
    assign head_x  = XW'(head);
    assign idx     = (ORDER == int'(SER_MSB)) ? LAST - cnt : cnt;
    assign beat    = head_x[idx*SW +: SW];
    assign str_bus = str_vld ? beat : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (str_trn) begin
            cnt <= str_lst ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_systemverilog_bus_serializer.sv
// Scoreboard bench: default 32/32/8 instance plus two MODE=1, SW=12 instances (both orders).
module tb_systemverilog_bus_serializer;

    typedef struct packed {
        logic [7:0] dat;
        logic       lst;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        bus_vld;
    logic [31:0] bus_adr;
    logic [31:0] bus_dat;
    logic        bus_rdy;
    logic        str_vld;
    logic [7:0]  str_bus;
    logic        str_lst;
    logic        str_rdy;

    logic        m_bus_vld;
    logic [31:0] m_bus_adr;
    logic [31:0] m_bus_dat;
    logic        m_str_rdy;
    logic        m0_bus_rdy, m1_bus_rdy;
    logic        m0_str_vld, m1_str_vld;
    logic [11:0] m0_str_bus, m1_str_bus;
    logic        m0_str_lst, m1_str_lst;

    int    vectors;
    int    miscompares;
    beat_t exp_q[$];

    systemverilog_bus_serializer dut (
        .clk     (clk),
        .rst     (rst),
        .bus_vld (bus_vld),
        .bus_adr (bus_adr),
        .bus_dat (bus_dat),
        .bus_rdy (bus_rdy),
        .str_vld (str_vld),
        .str_bus (str_bus),
        .str_lst (str_lst),
        .str_rdy (str_rdy)
    );

    systemverilog_bus_serializer #(.SW(12), .ORDER(0), .MODE(1)) dut_m0 (
        .clk     (clk),
        .rst     (rst),
        .bus_vld (m_bus_vld),
        .bus_adr (m_bus_adr),
        .bus_dat (m_bus_dat),
        .bus_rdy (m0_bus_rdy),
        .str_vld (m0_str_vld),
        .str_bus (m0_str_bus),
        .str_lst (m0_str_lst),
        .str_rdy (m_str_rdy)
    );

    systemverilog_bus_serializer #(.SW(12), .ORDER(1), .MODE(1)) dut_m1 (
        .clk     (clk),
        .rst     (rst),
        .bus_vld (m_bus_vld),
        .bus_adr (m_bus_adr),
        .bus_dat (m_bus_dat),
        .bus_rdy (m1_bus_rdy),
        .str_vld (m1_str_vld),
        .str_bus (m1_str_bus),
        .str_lst (m1_str_lst),
        .str_rdy (m_str_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Stream-side scoreboard and protocol monitor for the default instance.
    logic        hold_prev;
    logic [7:0]  prev_bus;
    logic        prev_lst;
    logic [63:0] mon_pkt;
    beat_t       mon_exp;

    initial hold_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            hold_prev = 1'b0;
        end else begin
            if (str_vld && str_rdy) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_extra: got beat %h lst %b, required no beat", str_bus, str_lst);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (str_bus !== mon_exp.dat || str_lst !== mon_exp.lst) begin
                        miscompares++;
                        $display("FAIL sb_beat: got %h lst %b, required %h lst %b",
                                 str_bus, str_lst, mon_exp.dat, mon_exp.lst);
                    end
                end
            end
            if (hold_prev) begin
                vectors++;
                if (str_vld !== 1'b1 || str_bus !== prev_bus || str_lst !== prev_lst) begin
                    miscompares++;
                    $display("FAIL hold: got vld %b bus %h lst %b, required vld 1 bus %h lst %b",
                             str_vld, str_bus, str_lst, prev_bus, prev_lst);
                end
            end
            if (!str_vld) begin
                vectors++;
                if (str_bus !== 8'h00 || str_lst !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_gate: got bus %h lst %b, required 00 0", str_bus, str_lst);
                end
            end
            hold_prev = str_vld && !str_rdy;
            prev_bus  = str_bus;
            prev_lst  = str_lst;
            if (bus_vld && bus_rdy) begin
                mon_pkt = {bus_adr, bus_dat};
                for (int k = 0; k < 8; k++)
                    exp_q.push_back(beat_t'{dat: mon_pkt[k*8 +: 8], lst: (k == 7)});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_one(input logic [31:0] adr, input logic [31:0] dat);
        int waited;
        waited  = 0;
        bus_vld = 1'b1;
        bus_adr = adr;
        bus_dat = dat;
        while (!bus_rdy && waited < 50) begin
            cyc();
            waited++;
        end
        if (!bus_rdy) begin
            vectors++;
            miscompares++;
            $display("FAIL write_timeout: bus_rdy stayed %b, required 1", bus_rdy);
        end
        cyc();
        bus_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        bus_vld   = 1'b0;
        bus_adr   = '0;
        bus_dat   = '0;
        str_rdy   = 1'b0;
        m_bus_vld = 1'b0;
        m_bus_adr = '0;
        m_bus_dat = '0;
        m_str_rdy = 1'b0;
        repeat (3) cyc();
        vectors++;
        if (bus_rdy !== 1'b1 || str_vld !== 1'b0 || str_lst !== 1'b0 || str_bus !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: got rdy %b vld %b lst %b bus %h, required 1 0 0 00",
                     bus_rdy, str_vld, str_lst, str_bus);
        end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        int n;
        str_rdy = 1'b1;
        write_one(32'h0706_0504, 32'h0302_0100);
        vectors++;
        if (str_vld !== 1'b1 || str_bus !== 8'h00) begin
            miscompares++;
            $display("FAIL single_latency: got vld %b bus %h, required 1 00", str_vld, str_bus);
        end
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (str_vld) n++;
            cyc();
        end
        vectors++;
        if (n != 8 || str_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL single_len: got %0d valid cycles, vld %b after, required 8 and 0", n, str_vld);
        end
    endtask

    task automatic test_stall();
        int nx;
        str_rdy = 1'b0;
        write_one(32'h1122_3344, 32'h5566_7788);
        nx = 0;
        for (int i = 0; i < 24; i++) begin
            str_rdy = (i % 2 == 0);
            #1;
            if (str_vld && str_rdy) nx++;
            cyc();
        end
        str_rdy = 1'b1;
        vectors++;
        if (nx != 8 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_count: got %0d transfers, %0d pending, required 8 and 0", nx, exp_q.size());
        end
    endtask

    task automatic test_full();
        int l_idx;
        int w_idx;
        str_rdy = 1'b0;
        bus_vld = 1'b1;
        bus_adr = 32'hA000_0001;
        bus_dat = 32'hA100_0001;
        cyc();
        bus_adr = 32'hB000_0002;
        bus_dat = 32'hB100_0002;
        cyc();
        bus_adr = 32'hC000_0003;
        bus_dat = 32'hC100_0003;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (bus_rdy !== 1'b0) begin
                miscompares++;
                $display("FAIL full_rdy: got bus_rdy %b with two packets held, required 0", bus_rdy);
            end
            cyc();
        end
        str_rdy = 1'b1;
        l_idx   = -1;
        w_idx   = -1;
        for (int i = 0; i < 40; i++) begin
            if (str_vld && str_rdy && str_lst && l_idx < 0) l_idx = i;
            if (bus_vld && bus_rdy && w_idx < 0) w_idx = i;
            cyc();
            if (w_idx >= 0) bus_vld = 1'b0;
        end
        bus_vld = 1'b0;
        vectors++;
        if (l_idx < 0 || w_idx != l_idx + 1) begin
            miscompares++;
            $display("FAIL full_accept: third write at cycle %0d, last beat at %0d, required last+1",
                     w_idx, l_idx);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL full_drain: got %0d pending beats, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int nx;
        int last;
        int gaps;
        logic [31:0] lst_mask;
        str_rdy = 1'b0;
        write_one(32'h1357_9BDF, 32'h2468_ACE0);
        write_one(32'hFEDC_BA98, 32'h7654_3210);
        str_rdy  = 1'b1;
        nx       = 0;
        last     = -1;
        gaps     = 0;
        lst_mask = '0;
        for (int i = 0; i < 20; i++) begin
            if (str_vld && str_rdy) begin
                if (last >= 0 && i != last + 1) gaps++;
                if (str_lst) lst_mask[nx] = 1'b1;
                nx++;
                last = i;
            end
            cyc();
        end
        vectors++;
        if (nx != 16 || gaps != 0) begin
            miscompares++;
            $display("FAIL b2b_flow: got %0d beats with %0d gaps, required 16 and 0", nx, gaps);
        end
        vectors++;
        if (lst_mask !== 32'h0000_8080) begin
            miscompares++;
            $display("FAIL b2b_lst: got lst mask %h, required 00008080", lst_mask);
        end
    endtask

    task automatic test_mode_dat();
        logic [11:0] exp0 [3];
        exp0[0] = 12'hEEF;
        exp0[1] = 12'hADB;
        exp0[2] = 12'h0DE;
        m_str_rdy = 1'b1;
        m_bus_adr = 32'hFFFF_FFFF;
        m_bus_dat = 32'hDEAD_BEEF;
        m_bus_vld = 1'b1;
        vectors++;
        if (m0_bus_rdy !== 1'b1 || m1_bus_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL mode_rdy: got %b %b, required 1 1", m0_bus_rdy, m1_bus_rdy);
        end
        cyc();
        m_bus_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (m0_str_vld !== 1'b1 || m0_str_bus !== exp0[k] || m0_str_lst !== (k == 2)) begin
                miscompares++;
                $display("FAIL mode_lsb beat%0d: got vld %b bus %h lst %b, required 1 %h %b",
                         k, m0_str_vld, m0_str_bus, m0_str_lst, exp0[k], (k == 2));
            end
            vectors++;
            if (m1_str_vld !== 1'b1 || m1_str_bus !== exp0[2-k] || m1_str_lst !== (k == 2)) begin
                miscompares++;
                $display("FAIL mode_msb beat%0d: got vld %b bus %h lst %b, required 1 %h %b",
                         k, m1_str_vld, m1_str_bus, m1_str_lst, exp0[2-k], (k == 2));
            end
            cyc();
        end
        vectors++;
        if (m0_str_vld !== 1'b0 || m1_str_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL mode_end: got vld %b %b, required 0 0", m0_str_vld, m1_str_vld);
        end
    endtask

    task automatic test_reset_mid();
        int nv;
        str_rdy = 1'b0;
        write_one(32'h0F0E_0D0C, 32'h0B0A_0908);
        write_one(32'h1F1E_1D1C, 32'h1B1A_1918);
        str_rdy = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        #1;
        exp_q.delete();
        vectors++;
        if (str_vld !== 1'b0 || bus_rdy !== 1'b1 || str_lst !== 1'b0 || str_bus !== 8'h00) begin
            miscompares++;
            $display("FAIL rstmid_out: got vld %b rdy %b lst %b bus %h, required 0 1 0 00",
                     str_vld, bus_rdy, str_lst, str_bus);
        end
        repeat (2) cyc();
        rst = 1'b1;
        nv  = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (str_vld) nv++;
        end
        vectors++;
        if (nv != 0) begin
            miscompares++;
            $display("FAIL rstmid_residual: got %0d valid cycles after release, required 0", nv);
        end
        write_one(32'hA0A1_A2A3, 32'hB0B1_B2B3);
        vectors++;
        if (str_vld !== 1'b1 || str_bus !== 8'hB3 || str_lst !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_restart: got vld %b bus %h lst %b, required 1 b3 0",
                     str_vld, str_bus, str_lst);
        end
        repeat (12) cyc();
        vectors++;
        if (exp_q.size() != 0 || str_vld !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_drain: got %0d pending, vld %b, required 0 and 0", exp_q.size(), str_vld);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_stall();
        test_full();
        test_back_to_back();
        test_mode_dat();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
